// File: rtl/axi4s_video_splitter_if.sv
// Multi-lane AXI4-Stream video bundle; VALID_WIDTH is 1 on the shared input side
// and NUM on the per-lane output side.
interface axi4s_video_splitter_if #(
    parameter int unsigned NUM         = 3,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned VALID_WIDTH = 1
);
    logic [NUM*TUSER_WIDTH-1:0] tuser;
    logic [NUM-1:0]             tlast;
    logic [NUM*TDATA_WIDTH-1:0] tdata;
    logic [VALID_WIDTH-1:0]     tvalid;
    logic [VALID_WIDTH-1:0]     tready;

    modport master (output tuser, tlast, tdata, tvalid, input tready);
    modport slave  (input tuser, tlast, tdata, tvalid, output tready);
endinterface

// File: rtl/axi4s_video_splitter.sv
// Fans one multi-lane AXI4-Stream video beat out to NUM independently stalling
// output streams, with an optional input skid buffer and lane-alignment checking.
module axi4s_video_splitter #(
    parameter int unsigned NUM           = 3,
    parameter int unsigned TUSER_WIDTH   = 1,
    parameter int unsigned TDATA_WIDTH   = 32,
    parameter int unsigned S_REGS        = 1,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     aclken,
    axi4s_video_splitter_if.slave    s_axi4s,
    axi4s_video_splitter_if.master   m_axi4s,
    input  logic                     clear_error,
    output logic                     misalign_error,
    output logic [ERR_CNT_WIDTH-1:0] misalign_count
);
    localparam int unsigned UW = NUM * TUSER_WIDTH;
    localparam int unsigned DW = NUM * TDATA_WIDTH;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM-1:0] lane_free;
    logic           all_free;
    logic           x_valid;
    logic [UW-1:0]  x_user;
    logic [NUM-1:0] x_last;
    logic [DW-1:0]  x_data;
    logic           accept;
    logic [NUM-1:0] x_sof;
    logic           misalign;
    logic           misalign_acc;

    logic [NUM-1:0] m_valid_q;
    logic [UW-1:0]  m_user_q;
    logic [NUM-1:0] m_last_q;
    logic [DW-1:0]  m_data_q;

    assign lane_free = ~m_valid_q | m_axi4s.tready;
    assign all_free  = &lane_free;
    assign accept    = x_valid & all_free & aclken;

    generate
        if (S_REGS != 0) begin : g_skid
            logic          skid_valid;
            logic          skid_valid_nxt;
            logic          ready_q;
            logic          in_hs;
            logic [UW-1:0] skid_user;
            logic [NUM-1:0] skid_last;
            logic [DW-1:0] skid_data;

            assign in_hs          = s_axi4s.tvalid[0] & ready_q & aclken;
            assign x_valid        = skid_valid | (s_axi4s.tvalid[0] & ready_q);
            assign x_user         = skid_valid ? skid_user : s_axi4s.tuser;
            assign x_last         = skid_valid ? skid_last : s_axi4s.tlast;
            assign x_data         = skid_valid ? skid_data : s_axi4s.tdata;
            // Skid holds a beat until every lane is free again; ready mirrors its emptiness.
            assign skid_valid_nxt = skid_valid ? ~all_free : (in_hs & ~all_free);
            assign s_axi4s.tready = ready_q;

            always_ff @(posedge aclk) begin
                if (reset) begin
                    skid_valid <= 1'b0;
                    ready_q    <= 1'b0;
                end else if (aclken) begin
                    skid_valid <= skid_valid_nxt;
                    ready_q    <= ~skid_valid_nxt;
                end
            end

            always_ff @(posedge aclk) begin
                if (in_hs && !all_free) begin
                    skid_user <= s_axi4s.tuser;
                    skid_last <= s_axi4s.tlast;
                    skid_data <= s_axi4s.tdata;
                end
            end
        end else begin : g_direct
            assign x_valid        = s_axi4s.tvalid[0];
            assign x_user         = s_axi4s.tuser;
            assign x_last         = s_axi4s.tlast;
            assign x_data         = s_axi4s.tdata;
            assign s_axi4s.tready = all_free & aclken & ~reset;
        end
    endgenerate

    // Per-lane output registers: load on accept, otherwise drop only lanes that were taken.
    always_ff @(posedge aclk) begin
        if (reset) begin
            m_valid_q <= '0;
        end else if (aclken) begin
            if (accept) begin
                m_valid_q <= '1;
            end else begin
                m_valid_q <= m_valid_q & ~m_axi4s.tready;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            m_user_q <= x_user;
            m_last_q <= x_last;
            m_data_q <= x_data;
        end
    end

    assign m_axi4s.tvalid = m_valid_q;
    assign m_axi4s.tuser  = m_user_q;
    assign m_axi4s.tlast  = m_last_q;
    assign m_axi4s.tdata  = m_data_q;

    always_comb begin
        x_sof = '0;
        for (int i = 0; i < int'(NUM); i++) begin
            x_sof[i] = x_user[i*TUSER_WIDTH];
        end
    end

    // A beat is misaligned when lanes disagree on start-of-frame or end-of-line.
    assign misalign     = ((|x_sof) & ~(&x_sof)) | ((|x_last) & ~(&x_last));
    assign misalign_acc = accept & misalign;

    always_ff @(posedge aclk) begin
        if (reset) begin
            misalign_error <= 1'b0;
            misalign_count <= '0;
        end else if (aclken) begin
            if (clear_error) begin
                misalign_error <= misalign_acc;
                misalign_count <= misalign_acc ? ERR_CNT_WIDTH'(1) : '0;
            end else if (misalign_acc) begin
                misalign_error <= 1'b1;
                if (misalign_count != CNT_MAX) begin
                    misalign_count <= misalign_count + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_axi4s_video_splitter.sv
// Bench for axi4s_video_splitter: one skid (S_REGS=1) and one direct (S_REGS=0,
// 3-bit counter) instance, with per-lane scoreboards fed from observed input handshakes.
module tb_axi4s_video_splitter;
    logic        aclk = 1'b0;
    logic        reset;
    logic        aclken;
    logic        clear_error;
    logic        sel;
    logic        s_tvalid;
    logic [95:0] s_tdata;
    logic [2:0]  s_tuser;
    logic [2:0]  s_tlast;
    logic [2:0]  m_tready;

    logic        err1, err0;
    logic [15:0] cnt1;
    logic [2:0]  cnt0;

    logic        o_sready;
    logic [2:0]  o_mvalid;
    logic [95:0] o_mdata;
    logic [2:0]  o_muser;
    logic [2:0]  o_mlast;
    logic        o_err;
    logic [15:0] o_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned seq = 0;
    int unsigned mis_seen = 0;
    bit          last_hs;

    logic [33:0] lq [3][$];
    logic [2:0]  prev_hold;
    logic [33:0] prev_beat [3];

    always #5 aclk = ~aclk;

    axi4s_video_splitter_if #(.NUM(3), .TUSER_WIDTH(1), .TDATA_WIDTH(32), .VALID_WIDTH(1)) if1_s ();
    axi4s_video_splitter_if #(.NUM(3), .TUSER_WIDTH(1), .TDATA_WIDTH(32), .VALID_WIDTH(3)) if1_m ();
    axi4s_video_splitter_if #(.NUM(3), .TUSER_WIDTH(1), .TDATA_WIDTH(32), .VALID_WIDTH(1)) if0_s ();
    axi4s_video_splitter_if #(.NUM(3), .TUSER_WIDTH(1), .TDATA_WIDTH(32), .VALID_WIDTH(3)) if0_m ();

    assign if1_s.tvalid = s_tvalid & sel;
    assign if1_s.tdata  = s_tdata;
    assign if1_s.tuser  = s_tuser;
    assign if1_s.tlast  = s_tlast;
    assign if1_m.tready = m_tready;
    assign if0_s.tvalid = s_tvalid & ~sel;
    assign if0_s.tdata  = s_tdata;
    assign if0_s.tuser  = s_tuser;
    assign if0_s.tlast  = s_tlast;
    assign if0_m.tready = m_tready;

    axi4s_video_splitter #(.NUM(3), .TUSER_WIDTH(1), .TDATA_WIDTH(32), .S_REGS(1), .ERR_CNT_WIDTH(16)) dut1 (
        .aclk(aclk), .reset(reset), .aclken(aclken), .s_axi4s(if1_s), .m_axi4s(if1_m),
        .clear_error(clear_error), .misalign_error(err1), .misalign_count(cnt1));

    axi4s_video_splitter #(.NUM(3), .TUSER_WIDTH(1), .TDATA_WIDTH(32), .S_REGS(0), .ERR_CNT_WIDTH(3)) dut0 (
        .aclk(aclk), .reset(reset), .aclken(aclken), .s_axi4s(if0_s), .m_axi4s(if0_m),
        .clear_error(clear_error), .misalign_error(err0), .misalign_count(cnt0));

    assign o_sready = sel ? if1_s.tready[0] : if0_s.tready[0];
    assign o_mvalid = sel ? if1_m.tvalid : if0_m.tvalid;
    assign o_mdata  = sel ? if1_m.tdata  : if0_m.tdata;
    assign o_muser  = sel ? if1_m.tuser  : if0_m.tuser;
    assign o_mlast  = sel ? if1_m.tlast  : if0_m.tlast;
    assign o_err    = sel ? err1 : err0;
    assign o_cnt    = sel ? cnt1 : 16'(cnt0);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_cnt();
        int unsigned mx;
        mx = sel ? 65535 : 7;
        return (mis_seen > mx) ? mx : mis_seen;
    endfunction

    // Reference model: every input handshake appends the beat to each lane's queue,
    // every output handshake must pop exactly that beat; stalled lanes must hold.
    always @(negedge aclk) begin
        logic [33:0] obs;
        logic [2:0]  u, l;
        bit          hs_mis;
        if (reset) begin
            for (int i = 0; i < 3; i++) lq[i].delete();
            mis_seen  = 0;
            prev_hold = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                obs = {o_mdata[i*32 +: 32], o_muser[i], o_mlast[i]};
                if (prev_hold[i]) begin
                    check("hold_valid", 128'(o_mvalid[i]), 128'(1));
                    check("hold_beat", 128'(obs), 128'(prev_beat[i]));
                end
                if (aclken && o_mvalid[i] && m_tready[i]) begin
                    check("lane_nonempty", 128'(lq[i].size() != 0), 128'(1));
                    if (lq[i].size() != 0) check("lane_beat", 128'(obs), 128'(lq[i].pop_front()));
                end
                prev_hold[i] = o_mvalid[i] && !(m_tready[i] && aclken);
                prev_beat[i] = obs;
            end
            if (aclken) begin
                hs_mis = 1'b0;
                if (s_tvalid && o_sready) begin
                    for (int i = 0; i < 3; i++) lq[i].push_back({s_tdata[i*32 +: 32], s_tuser[i], s_tlast[i]});
                    u = s_tuser;
                    l = s_tlast;
                    hs_mis = !((u == 3'b000) || (u == 3'b111)) || !((l == 3'b000) || (l == 3'b111));
                end
                if (clear_error) mis_seen = hs_mis ? 1 : 0;
                else if (hs_mis) mis_seen++;
            end
        end
    end

    task automatic tick();
        @(negedge aclk);
        last_hs = s_tvalid && o_sready && aclken && !reset;
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic drive_beat(input int unsigned sq, input logic [2:0] u, input logic [2:0] l);
        for (int i = 0; i < 3; i++) s_tdata[i*32 +: 32] = {8'(i), 24'(sq)};
        s_tuser = u;
        s_tlast = l;
    endtask

    task automatic send(input logic [2:0] u, input logic [2:0] l);
        int n;
        n = 0;
        drive_beat(seq, u, l);
        s_tvalid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_hs && n < 200);
        check("send_handshake", 128'(last_hs), 128'(1));
        s_tvalid = 1'b0;
        seq++;
    endtask

    task automatic run_random(input int nbeats);
        int sent, guard;
        sent = 0;
        guard = 0;
        while (sent < nbeats && guard < 40000) begin
            if (!s_tvalid && ($urandom_range(1, 0) == 1)) begin
                drive_beat(seq, (seq % 1024 == 0) ? 3'b111 : 3'b000, (seq % 64 == 63) ? 3'b111 : 3'b000);
                s_tvalid = 1'b1;
            end
            m_tready = 3'($urandom);
            tick();
            guard++;
            if (last_hs) begin
                s_tvalid = 1'b0;
                seq++;
                sent++;
            end
        end
        check("random_progress", 128'(sent), 128'(nbeats));
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        m_tready = 3'b111;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) check("drain_empty", 128'(lq[i].size()), 128'(0));
        check("drain_valid", 128'(o_mvalid), 128'(0));
        check("err_count", 128'(o_cnt), 128'(exp_cnt()));
        check("err_flag", 128'(o_err), 128'(mis_seen != 0));
    endtask

    task automatic pulse_reset();
        s_tvalid = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        check("rst_valid", 128'(o_mvalid), 128'(0));
        check("rst_sready", 128'(o_sready), 128'(0));
        check("rst_err", 128'(o_err), 128'(0));
        check("rst_cnt", 128'(o_cnt), 128'(0));
        reset = 1'b0;
        tick();
    endtask

    task automatic freeze_check();
        logic [2:0]  v;
        logic [95:0] d;
        logic        r;
        drive_beat(seq, 3'b000, 3'b000);
        s_tvalid = 1'b1;
        v = o_mvalid;
        d = o_mdata;
        r = o_sready;
        aclken = 1'b0;
        repeat (5) begin
            m_tready = 3'($urandom);
            tick();
            check("frz_valid", 128'(o_mvalid), 128'(v));
            check("frz_data", 128'(o_mdata), 128'(d));
            check("frz_sready", 128'(o_sready), sel ? 128'(r) : 128'(0));
        end
        aclken = 1'b1;
    endtask

    initial begin
        int unsigned c0, s0;
        reset = 1'b1;
        aclken = 1'b1;
        clear_error = 1'b0;
        sel = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tuser = '0;
        s_tlast = '0;
        m_tready = 3'b111;

        // Reset state, then registered ready rises one cycle after release.
        pulse_reset();
        check("sready_after_rst", 128'(o_sready), 128'(1));

        // Full 64x16 frame, all lanes ready: one beat per cycle, one-cycle latency.
        c0 = cyc;
        for (int k = 0; k < 1024; k++) begin
            s0 = seq;
            send((k == 0) ? 3'b111 : 3'b000, (k % 64 == 63) ? 3'b111 : 3'b000);
            if (k == 0) begin
                check("t1_latency_valid", 128'(o_mvalid), 128'(3'b111));
                check("t1_latency_data", 128'(o_mdata[31:0]), 128'({8'd0, 24'(s0)}));
            end
        end
        check("t1_rate", 128'(cyc - c0), 128'(1024));
        drain();

        // Lane 1 stalls: lanes 0/2 take one beat, second beat parks in the skid.
        m_tready = 3'b101;
        send(3'b111, 3'b000);
        send(3'b000, 3'b000);
        repeat (8) begin
            check("t2_sready_low", 128'(o_sready), 128'(0));
            tick();
        end
        check("t2_valid", 128'(o_mvalid), 128'(3'b010));
        check("t2_q0", 128'(lq[0].size()), 128'(1));
        check("t2_q1", 128'(lq[1].size()), 128'(2));
        m_tready = 3'b111;
        send(3'b000, 3'b000);
        drain();

        // Misaligned beats are counted and forwarded unchanged.
        send(3'b011, 3'b000);
        send(3'b000, 3'b100);
        drain();
        check("t4_cnt", 128'(o_cnt), 128'(2));
        check("t4_err", 128'(o_err), 128'(1));

        // Clear coincident with a misaligned accept leaves error=1, count=1.
        clear_error = 1'b1;
        send(3'b101, 3'b000);
        clear_error = 1'b0;
        drain();
        check("t5_cnt", 128'(o_cnt), 128'(1));

        // Reset with the skid full discards everything in flight.
        m_tready = 3'b000;
        send(3'b111, 3'b000);
        send(3'b000, 3'b000);
        check("t6_sready_full", 128'(o_sready), 128'(0));
        check("t6_valid_full", 128'(o_mvalid), 128'(3'b111));
        pulse_reset();
        m_tready = 3'b111;
        repeat (3) tick();
        check("t6_skid_empty", 128'(o_mvalid), 128'(0));
        check("t6_sready", 128'(o_sready), 128'(1));

        // Random traffic with a mid-stream clock-enable freeze, skid instance.
        run_random(40);
        freeze_check();
        run_random(3072);
        drain();

        // Direct (combinational ready) instance.
        sel = 1'b0;
        pulse_reset();
        check("d0_sready_idle", 128'(o_sready), 128'(1));
        run_random(40);
        freeze_check();
        run_random(3072);
        drain();

        // 3-bit counter saturates at 7.
        for (int k = 0; k < 9; k++) send(3'b001, 3'b000);
        drain();
        check("sat_cnt", 128'(o_cnt), 128'(7));
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        tick();
        check("clr_cnt", 128'(o_cnt), 128'(0));
        check("clr_err", 128'(o_err), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4s_video_splitter.md
Name: axi4s_video_splitter

Overview:
- Downstream counterpart of the video combiner. Takes one AXI4-Stream video beat carrying NUM lanes of tdata, tuser and tlast, and fans it out to NUM independent AXI4-Stream outputs.
- Each output has its own tready, and each lane is allowed to stall independently.
- An input beat is released only when every lane has consumed the previous one.
- Lane-misalignment checking (tuser/tlast disagreement between lanes) flags upstream framing faults.

Parameters:
- NUM, 3: number of output lanes (≥1).
- TUSER_WIDTH, 1: tuser bits per lane. Bit 0 of each lane's tuser is start-of-frame.
- TDATA_WIDTH, 32: tdata bits per lane.
- S_REGS, 1: 1 inserts a one-entry input skid buffer so s_axi4s_tready is a register output. 0 makes s_axi4s_tready combinational.
- ERR_CNT_WIDTH, 16: width of the misalignment counter.

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- aclken  in  1  clock enable. All state holds when 0.
- s_axi4s_tuser  in  NUM*TUSER_WIDTH  per-lane tuser.
- s_axi4s_tlast  in  NUM  per-lane tlast.
- s_axi4s_tdata  in  NUM*TDATA_WIDTH  per-lane tdata.
- s_axi4s_tvalid  in  1  input valid.
- s_axi4s_tready  out  1  input ready.
- m_axi4s_tuser  out  NUM*TUSER_WIDTH  per-lane tuser.
- m_axi4s_tlast  out  NUM  per-lane tlast.
- m_axi4s_tdata  out  NUM*TDATA_WIDTH  per-lane tdata.
- m_axi4s_tvalid  out  NUM  per-lane valid.
- m_axi4s_tready  in  NUM  per-lane ready.
- clear_error  in  1  pulse that clears the sticky error state.
- misalign_error  out  1  sticky misalignment flag.
- misalign_count  out  ERR_CNT_WIDTH  saturating count of misaligned beats.

Behaviour:
- Reset (reset=1 at a rising edge of aclk):
  - m_axi4s_tvalid=0; skid buffer empty; misalign_error=0; misalign_count=0.
  - s_axi4s_tready=0 during reset. With S_REGS=1 it is 1 from the first cycle after reset deasserts.
  - Data/user/last registers are don't-care.
- Transfers happen only on edges with aclken=1. With aclken=0, every register holds and no handshake is counted on any port.
- Lane i is free when !m_axi4s_tvalid[i] || m_axi4s_tready[i].
- all_free is the AND over all lanes of "lane free".
- Internal beat x:
  - S_REGS=1: x is the skid entry if it is valid, otherwise the s_axi4s_* inputs. s_axi4s_tready = !skid_valid (registered).
  - S_REGS=0: x is the s_axi4s_* inputs. s_axi4s_tready = all_free & aclken.
- x is accepted when x is valid and all_free:
  - Every lane loads its slice of tdata, tuser and tlast, and sets m_axi4s_tvalid[i]=1.
  - Latency from input handshake to m_axi4s_tvalid is 1 cycle.
  - Sustained 1 beat/cycle when all lanes are ready.
- No accept this cycle: every lane with m_axi4s_tready[i]=1 clears m_axi4s_tvalid[i]. Other lanes hold data and valid unchanged (AXI stability rule).
- Skid buffer (S_REGS=1):
  - Capture: an input handshake while !all_free, or while the skid is already draining nothing, writes the input beat into the skid; skid_valid=1.
  - Release: skid_valid clears on the cycle the skid beat is accepted.
  - Input handshake and skid drain in the same cycle cannot occur, because s_axi4s_tready=0 whenever the skid is full.
- Ordering: beats leave every lane in input order. No beat is dropped or duplicated.
- Misalignment check, evaluated on each accepted beat x:
  - Misaligned when tuser bit 0 differs between any lanes, OR tlast differs between any lanes.
  - A misaligned beat is still forwarded unchanged.
  - The following cycle: misalign_error=1 and misalign_count increments, saturating at all-ones.
- clear_error=1 zeroes misalign_error and misalign_count. If a misaligned accept occurs in the same cycle as clear_error, the result is error=1, count=1.
- reset mid-frame: all in-flight beats, including any skid content, are discarded. There is no resynchronisation to the next frame start; the block is purely beat-level.
- NUM=1: degenerates to a register slice with a checker that never fires.

Test Plan:
1. All m_axi4s_tready=1, tvalid=1, 64×16 frame, lane data {i,seq} → each lane outputs the 1024 beats in order. 1 beat/cycle after 1-cycle latency. misalign_count=0.
2. Lane 1 tready held 0 for 10 cycles while lanes 0 and 2 ready → lanes 0/2 deliver exactly one beat and then hold valid=0. Lane 1 holds its beat stable. s_axi4s_tready=0 from the second beat until lane 1 releases. No beat is lost.
3. Random per-lane tready at 50% and random s tvalid, 3 frames → per-lane scoreboards match the input sequence exactly. Repeat with S_REGS=0 and S_REGS=1.
4. Inject a beat with tuser = 3'b011 (lane 2 missing start-of-frame), then a beat with tlast = 3'b100 → misalign_error=1, misalign_count=2. Both beats are forwarded unchanged.
5. clear_error asserted in the same cycle as a misaligned accept → misalign_count=1, misalign_error=1. Force the counter to 0xFFFF and inject one more misaligned beat → the count stays 0xFFFF.
6. reset asserted with the skid full and all lanes valid → the next cycle has all m_axi4s_tvalid=0 and the skid empty. aclken=0 for 5 cycles mid-stream → outputs frozen, no handshakes counted, and the stream resumes intact.
